// File: rtl/lcd_spi_if_gen2.sv
// SPI master for the picture-frame LCD: single CMD/DATA bytes with a D/C line, plus STREAM bursts with a one-word prefetch.
// Latency: CS falls the cycle after trigger; a CMD/DATA byte keeps busy high 17*CLK_DIV+CS_IDLE cycles, done pulses next.
// Backpressure: stream_busy is high outside STREAM, while the prefetch buffer is full, and once every burst word is in.
module lcd_spi_if_gen2 #(
    parameter int CLK_DIV     = 2,
    parameter int WORD_BYTES  = 4,
    parameter int BURST_BYTES = 512,
    parameter int CS_IDLE     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              op,
    input  logic [7:0]              cmd_byte,
    input  logic                    trigger,
    output logic                    busy,
    output logic                    done,
    input  logic [8*WORD_BYTES-1:0] stream_data,
    input  logic                    stream_trigger,
    output logic                    stream_busy,
    output logic                    spi_clk,
    output logic                    spi_mosi,
    input  logic                    spi_miso,
    output logic                    spi_cs,
    output logic                    lcd_dc
);
    localparam int WW     = 8 * WORD_BYTES;
    localparam int NWORDS = BURST_BYTES / WORD_BYTES;
    localparam int BCW    = $clog2(BURST_BYTES + 1);
    localparam int DCW    = $clog2(CLK_DIV + 1);
    localparam int GCW    = $clog2(CS_IDLE + 1);
    localparam int WCW    = $clog2(NWORDS + 1);
    localparam int WBW    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [1:0] OP_CMD    = 2'b00;
    localparam logic [1:0] OP_STREAM = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_WAIT_WORD, S_HOLD, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              dc_q, dc_d, cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d;
    logic              busy_q, busy_d, done_q, done_d, sbusy_q, sbusy_d;
    logic [WW-1:0]     sh_q, sh_d, buf_q, buf_d;
    logic              buf_vld_q, buf_vld_d;
    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [WCW-1:0]    words_q, words_d;
    logic [WBW-1:0]    wbyte_q, wbyte_d;
    logic [2:0]        bit_q, bit_d;
    logic [DCW-1:0]    div_q, div_d;
    logic [GCW-1:0]    gap_q, gap_d;
    logic              accept;
    logic [BCW-1:0]    last_idx;
    logic              unused_miso;

    // MISO has no reader: the LCD is write-only.
    assign unused_miso = spi_miso;

    assign busy        = busy_q;
    assign done        = done_q;
    assign stream_busy = sbusy_q;
    assign spi_clk     = sck_q;
    assign spi_mosi    = mosi_q;
    assign spi_cs      = cs_q;
    assign lcd_dc      = dc_q;

    // Next-state logic: bit timing, byte/word sequencing, prefetch buffer handling.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dc_d       = dc_q;
        cs_d       = cs_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sh_d       = sh_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        byte_cnt_d = byte_cnt_q;
        words_d    = words_q;
        wbyte_d    = wbyte_q;
        bit_d      = bit_q;
        div_d      = div_q;
        gap_d      = gap_q;
        accept     = stream_trigger && !sbusy_q;
        last_idx   = (op_q == OP_STREAM) ? BCW'(BURST_BYTES - 1) : '0;

        case (state_q)
            S_IDLE: begin
                if (trigger && op != OP_RSVD) begin
                    op_d       = op;
                    dc_d       = (op != OP_CMD);
                    cs_d       = 1'b0;
                    busy_d     = 1'b1;
                    sck_d      = 1'b0;
                    div_d      = '0;
                    byte_cnt_d = '0;
                    words_d    = '0;
                    buf_vld_d  = 1'b0;
                    if (op == OP_STREAM) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d              = S_SHIFT;
                        sh_d                 = '0;
                        sh_d[WW-1 -: 8]      = cmd_byte;
                        mosi_d               = cmd_byte[7];
                        bit_d                = 3'd7;
                        wbyte_d              = '0;
                    end
                end
            end
            // Shifter empty (burst start or underrun): SCK and MOSI hold until a word arrives.
            S_LOAD, S_WAIT_WORD: begin
                if (accept) begin
                    sh_d    = stream_data;
                    mosi_d  = stream_data[WW-1];
                    bit_d   = 3'd7;
                    wbyte_d = WBW'(WORD_BYTES - 1);
                    words_d = words_q + 1'b1;
                    div_d   = '0;
                    sck_d   = 1'b0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (accept) begin
                    buf_d     = stream_data;
                    buf_vld_d = 1'b1;
                    words_d   = words_q + 1'b1;
                end
                if (div_q != DCW'(CLK_DIV - 1)) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q != 3'd0) begin
                            bit_d  = bit_q - 3'd1;
                            sh_d   = sh_q << 1;
                            mosi_d = sh_q[WW-2];
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            bit_d      = 3'd7;
                            if (byte_cnt_q == last_idx) begin
                                state_d = S_HOLD;
                            end else if (wbyte_q != '0) begin
                                wbyte_d = wbyte_q - 1'b1;
                                sh_d    = sh_q << 1;
                                mosi_d  = sh_q[WW-2];
                            end else if (buf_vld_q) begin
                                sh_d      = buf_q;
                                mosi_d    = buf_q[WW-1];
                                buf_vld_d = 1'b0;
                                wbyte_d   = WBW'(WORD_BYTES - 1);
                            end else if (accept) begin
                                // Word arriving exactly at the word boundary bypasses the buffer.
                                sh_d      = stream_data;
                                mosi_d    = stream_data[WW-1];
                                buf_vld_d = 1'b0;
                                wbyte_d   = WBW'(WORD_BYTES - 1);
                            end else begin
                                state_d = S_WAIT_WORD;
                            end
                        end
                    end
                end
            end
            // Final SCK-low hold with CS still asserted.
            S_HOLD: begin
                if (div_q == DCW'(CLK_DIV - 1)) begin
                    div_d   = '0;
                    gap_d   = '0;
                    cs_d    = 1'b1;
                    state_d = S_GAP;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GCW'(CS_IDLE - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        sbusy_d = !((op_d == OP_STREAM) &&
                    (state_d inside {S_LOAD, S_SHIFT, S_WAIT_WORD}) &&
                    !buf_vld_d && (words_d < WCW'(NWORDS)));
    end

    // State and registered outputs; synchronous reset aborts any op without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_CMD;
            dc_q       <= 1'b1;
            cs_q       <= 1'b1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sbusy_q    <= 1'b1;
            sh_q       <= '0;
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
            byte_cnt_q <= '0;
            words_q    <= '0;
            wbyte_q    <= '0;
            bit_q      <= '0;
            div_q      <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dc_q       <= dc_d;
            cs_q       <= cs_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sbusy_q    <= sbusy_d;
            sh_q       <= sh_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            byte_cnt_q <= byte_cnt_d;
            words_q    <= words_d;
            wbyte_q    <= wbyte_d;
            bit_q      <= bit_d;
            div_q      <= div_d;
            gap_q      <= gap_d;
        end
    end
endmodule

// File: tb/tb_lcd_spi_if_gen2.sv
// Directed bench for lcd_spi_if_gen2 with an 8-byte burst and 4-byte words.
// Latency: N/A (bench).
// Backpressure: stream words are offered only while stream_busy is low, except where ignore is exercised.
module tb_lcd_spi_if_gen2;
    localparam int CLK_DIV = 2;
    localparam int WB      = 4;
    localparam int BURST   = 8;
    localparam int CS_IDLE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  op = 2'b00;
    logic [7:0]  cmd_byte = 8'h00;
    logic        trigger = 1'b0;
    logic        busy, done, stream_busy, spi_clk, spi_mosi, spi_cs, lcd_dc;
    logic [31:0] stream_data = 32'h0;
    logic        stream_trigger = 1'b0;
    logic        spi_miso = 1'b0;

    int total = 0;
    int bad = 0;

    // Bus monitor state, sampled 2 time units after each rising edge.
    logic [7:0] rx_bytes[$];
    logic [7:0] acc = 8'h00;
    int nbits = 0;
    logic prev_sck = 1'b0;
    int cs_low_cnt = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int cs_hi_run = 0;
    int last_gap = 0;

    always #5 clk = ~clk;

    lcd_spi_if_gen2 #(
        .CLK_DIV(CLK_DIV), .WORD_BYTES(WB), .BURST_BYTES(BURST), .CS_IDLE(CS_IDLE)
    ) dut (
        .clk(clk), .rst(rst), .op(op), .cmd_byte(cmd_byte), .trigger(trigger),
        .busy(busy), .done(done), .stream_data(stream_data), .stream_trigger(stream_trigger),
        .stream_busy(stream_busy), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs(spi_cs), .lcd_dc(lcd_dc)
    );

    // Decode MOSI on SCK rises and count CS/busy/done activity.
    always begin
        @(posedge clk);
        #2;
        if (spi_clk === 1'b1 && prev_sck === 1'b0) begin
            acc = {acc[6:0], spi_mosi};
            nbits++;
            if (nbits == 8) begin
                rx_bytes.push_back(acc);
                nbits = 0;
            end
        end
        prev_sck = spi_clk;
        if (spi_cs === 1'b0) begin
            if (cs_hi_run > 0) last_gap = cs_hi_run;
            cs_hi_run = 0;
            cs_low_cnt++;
        end else begin
            cs_hi_run++;
        end
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic clear_mon();
        rx_bytes.delete();
        nbits = 0;
        cs_low_cnt = 0;
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Starts a STREAM op and offers the first word as soon as it can be taken.
    task automatic stream_start(output bit ok);
        op = 2'b10;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (stream_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        stream_data = 32'h01020304;
        stream_trigger = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (spi_cs !== 1'b1)      begin bad++; $display("FAIL reset_cs got=%b want=1", spi_cs); end
        total++; if (spi_clk !== 1'b0)     begin bad++; $display("FAIL reset_sck got=%b want=0", spi_clk); end
        total++; if (spi_mosi !== 1'b0)    begin bad++; $display("FAIL reset_mosi got=%b want=0", spi_mosi); end
        total++; if (lcd_dc !== 1'b1)      begin bad++; $display("FAIL reset_dc got=%b want=1", lcd_dc); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (stream_busy !== 1'b1) begin bad++; $display("FAIL reset_sbusy got=%b want=1", stream_busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cmd();
        bit ok;
        clear_mon();
        op = 2'b00;
        cmd_byte = 8'h2A;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        total++; if (spi_cs !== 1'b0) begin bad++; $display("FAIL cmd_cs_low got=%b want=0", spi_cs); end
        total++; if (lcd_dc !== 1'b0) begin bad++; $display("FAIL cmd_dc got=%b want=0", lcd_dc); end
        total++; if (busy !== 1'b1)   begin bad++; $display("FAIL cmd_busy got=%b want=1", busy); end
        wait_done(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL cmd_done_timeout got=none want=done"); end
        total++; if (cs_low_cnt != 34) begin bad++; $display("FAIL cmd_cs_len got=%0d want=34", cs_low_cnt); end
        total++; if (busy_cnt != 36)   begin bad++; $display("FAIL cmd_busy_len got=%0d want=36", busy_cnt); end
        total++; if (rx_bytes.size() != 1) begin bad++; $display("FAIL cmd_nbytes got=%0d want=1", rx_bytes.size()); end
        total++; if (rx_bytes[0] !== 8'h2A) begin bad++; $display("FAIL cmd_byte got=%h want=2a", rx_bytes[0]); end
        total++; if (done_cnt != 1)    begin bad++; $display("FAIL cmd_done_cnt got=%0d want=1", done_cnt); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL cmd_busy_at_done got=%b want=0", busy); end
    endtask

    // DATA op triggered on the very cycle done pulses.
    task automatic test_back_to_back();
        bit ok;
        clear_mon();
        op = 2'b01;
        cmd_byte = 8'hA5;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        total++; if (spi_cs !== 1'b0) begin bad++; $display("FAIL b2b_cs_low got=%b want=0", spi_cs); end
        total++; if (lcd_dc !== 1'b1) begin bad++; $display("FAIL b2b_dc got=%b want=1", lcd_dc); end
        total++; if (last_gap < CS_IDLE) begin bad++; $display("FAIL b2b_cs_gap got=%0d want>=%0d", last_gap, CS_IDLE); end
        wait_done(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_done_timeout got=none want=done"); end
        total++; if (rx_bytes.size() != 1) begin bad++; $display("FAIL b2b_nbytes got=%0d want=1", rx_bytes.size()); end
        total++; if (rx_bytes[0] !== 8'hA5) begin bad++; $display("FAIL b2b_byte got=%h want=a5", rx_bytes[0]); end
        total++; if (cs_low_cnt != 34) begin bad++; $display("FAIL b2b_cs_len got=%0d want=34", cs_low_cnt); end
        repeat (3) @(negedge clk);
        total++; if (done_cnt != 1) begin bad++; $display("FAIL b2b_done_cnt got=%0d want=1", done_cnt); end
    endtask

    task automatic test_stream();
        bit ok;
        logic [7:0] exp [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        clear_mon();
        stream_start(ok);
        total++; if (!ok) begin bad++; $display("FAIL strm_first_accept got=busy want=ready"); end
        total++; if (stream_busy !== 1'b0) begin bad++; $display("FAIL strm_sbusy_w1 got=%b want=0", stream_busy); end
        stream_data = 32'h05060708;
        @(negedge clk);
        total++; if (stream_busy !== 1'b1) begin bad++; $display("FAIL strm_sbusy_w2 got=%b want=1", stream_busy); end
        // Words offered while stream_busy is high must be dropped.
        stream_data = 32'hDEADBEEF;
        repeat (4) @(negedge clk);
        stream_trigger = 1'b0;
        wait_done(600, ok);
        total++; if (!ok) begin bad++; $display("FAIL strm_done_timeout got=none want=done"); end
        // One LOAD cycle to take word 1, 8 gapless bytes, then the CLK_DIV hold.
        total++; if (cs_low_cnt != 1 + 8*16*CLK_DIV + CLK_DIV)
            begin bad++; $display("FAIL strm_cs_len got=%0d want=%0d", cs_low_cnt, 1 + 8*16*CLK_DIV + CLK_DIV); end
        total++; if (rx_bytes.size() != 8) begin bad++; $display("FAIL strm_nbytes got=%0d want=8", rx_bytes.size()); end
        for (int i = 0; i < 8; i++) begin
            total++; if (rx_bytes[i] !== exp[i]) begin bad++; $display("FAIL strm_byte%0d got=%h want=%h", i, rx_bytes[i], exp[i]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL strm_done_cnt got=%0d want=1", done_cnt); end
        total++; if (stream_busy !== 1'b1) begin bad++; $display("FAIL strm_sbusy_end got=%b want=1", stream_busy); end
    endtask

    task automatic test_stream_stall();
        bit ok;
        int stall_bad;
        logic [7:0] exp [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        clear_mon();
        stream_start(ok);
        stream_trigger = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL stall_first_accept got=busy want=ready"); end
        // Word 1 occupies the next 128 cycles; the underrun starts right after.
        repeat (128) @(negedge clk);
        stall_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (spi_clk !== 1'b0 || spi_cs !== 1'b0) stall_bad++;
            @(negedge clk);
        end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_lines got=%0d bad cycles want=0", stall_bad); end
        total++; if (rx_bytes.size() != 4) begin bad++; $display("FAIL stall_nbytes_mid got=%0d want=4", rx_bytes.size()); end
        total++; if (stream_busy !== 1'b0) begin bad++; $display("FAIL stall_sbusy got=%b want=0", stream_busy); end
        stream_data = 32'h05060708;
        stream_trigger = 1'b1;
        @(negedge clk);
        stream_trigger = 1'b0;
        wait_done(600, ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_done_timeout got=none want=done"); end
        // 41 underrun cycles on top of the 259-cycle gapless burst.
        total++; if (cs_low_cnt != 300) begin bad++; $display("FAIL stall_cs_len got=%0d want=300", cs_low_cnt); end
        total++; if (rx_bytes.size() != 8) begin bad++; $display("FAIL stall_nbytes got=%0d want=8", rx_bytes.size()); end
        for (int i = 0; i < 8; i++) begin
            total++; if (rx_bytes[i] !== exp[i]) begin bad++; $display("FAIL stall_byte%0d got=%h want=%h", i, rx_bytes[i], exp[i]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL stall_done_cnt got=%0d want=1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        stream_start(ok);
        stream_trigger = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (spi_cs !== 1'b1)      begin bad++; $display("FAIL rmid_cs got=%b want=1", spi_cs); end
        total++; if (spi_clk !== 1'b0)     begin bad++; $display("FAIL rmid_sck got=%b want=0", spi_clk); end
        total++; if (spi_mosi !== 1'b0)    begin bad++; $display("FAIL rmid_mosi got=%b want=0", spi_mosi); end
        total++; if (lcd_dc !== 1'b1)      begin bad++; $display("FAIL rmid_dc got=%b want=1", lcd_dc); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
        total++; if (stream_busy !== 1'b1) begin bad++; $display("FAIL rmid_sbusy got=%b want=1", stream_busy); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (done_cnt != 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", done_cnt); end
        clear_mon();
        op = 2'b00;
        cmd_byte = 8'h3C;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        wait_done(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_cmd_timeout got=none want=done"); end
        total++; if (rx_bytes.size() != 1) begin bad++; $display("FAIL rmid_nbytes got=%0d want=1", rx_bytes.size()); end
        total++; if (rx_bytes[0] !== 8'h3C) begin bad++; $display("FAIL rmid_byte got=%h want=3c", rx_bytes[0]); end
        total++; if (cs_low_cnt != 34) begin bad++; $display("FAIL rmid_cs_len got=%0d want=34", cs_low_cnt); end
    endtask

    task automatic test_ignored();
        bit ok;
        int idle_bad;
        // Reserved op and a stray stream word in IDLE; last op was CMD 0x3C so dc=0, mosi=0.
        clear_mon();
        op = 2'b11;
        trigger = 1'b1;
        stream_data = 32'h11223344;
        stream_trigger = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || spi_cs !== 1'b1 || spi_clk !== 1'b0 || spi_mosi !== 1'b0 ||
                stream_busy !== 1'b1 || done !== 1'b0 || lcd_dc !== 1'b0) idle_bad++;
        end
        trigger = 1'b0;
        stream_trigger = 1'b0;
        total++; if (idle_bad != 0) begin bad++; $display("FAIL ign_idle got=%0d changed cycles want=0", idle_bad); end
        total++; if (rx_bytes.size() != 0) begin bad++; $display("FAIL ign_idle_bytes got=%0d want=0", rx_bytes.size()); end
        // A DATA trigger while a CMD is running must not be taken.
        clear_mon();
        op = 2'b00;
        cmd_byte = 8'h81;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        repeat (3) @(negedge clk);
        op = 2'b01;
        cmd_byte = 8'hFF;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        total++; if (lcd_dc !== 1'b0) begin bad++; $display("FAIL ign_busy_dc got=%b want=0", lcd_dc); end
        wait_done(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL ign_busy_timeout got=none want=done"); end
        total++; if (rx_bytes.size() != 1) begin bad++; $display("FAIL ign_busy_nbytes got=%0d want=1", rx_bytes.size()); end
        total++; if (rx_bytes[0] !== 8'h81) begin bad++; $display("FAIL ign_busy_byte got=%h want=81", rx_bytes[0]); end
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy_after got=%b want=0", busy); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL ign_busy_done_cnt got=%0d want=1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_cmd();
        test_back_to_back();
        test_stream();
        test_stream_stall();
        test_reset_mid();
        test_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
